// File: rtl/gpio_bcd_display_if.sv
// gpio_bcd_display_if: bundles the CPU HEX-port write and the display outputs.
//   master: CPU side; drives gpio_we/gpio_data and observes the display outputs.
//   slave : display converter; samples the write and drives busy/done/bcd/hex/ovf.
interface gpio_bcd_display_if #(
  parameter int unsigned NDIGITS = 8
);
  logic                   gpio_we;
  logic [31:0]            gpio_data;
  logic                   busy;
  logic                   done;
  logic [4*NDIGITS-1:0]   bcd;
  logic [7*NDIGITS-1:0]   hex;
  logic                   ovf;

  modport master (
    output gpio_we, gpio_data,
    input  busy, done, bcd, hex, ovf
  );

  modport slave (
    input  gpio_we, gpio_data,
    output busy, done, bcd, hex, ovf
  );
endinterface

// File: rtl/gpio_bcd_display.sv
// gpio_bcd_display: converts a 32-bit unsigned GPIO/HEX write to decimal with a
// one-bit-per-cycle shift-add-3 engine and drives registered BCD digits and
// active-low seven-segment patterns with leading-zero blanking.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   bus   - gpio_bcd_display_if.slave: gpio_we/gpio_data in; busy, done, bcd, hex, ovf out
// A single-entry pending buffer absorbs writes that arrive mid-conversion.
module gpio_bcd_display #(
  parameter int unsigned NDIGITS = 8
) (
  input logic                clk,
  input logic                rst_n,
  gpio_bcd_display_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            bin_sh_q, bin_sh_d;
  logic [39:0]            bcd_acc_q, bcd_acc_d;
  logic [5:0]             cnt_q, cnt_d;
  logic                   pend_v_q, pend_v_d;
  logic [31:0]            pend_data_q, pend_data_d;
  logic [4*NDIGITS-1:0]   bcd_q, bcd_d;
  logic [7*NDIGITS-1:0]   hex_q, hex_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;

  logic [39:0]            adj_acc;
  logic [39:0]            shifted_acc;
  logic [9:0]             blank;
  logic [7*NDIGITS-1:0]   hex_new;
  logic [7*NDIGITS-1:0]   hex_rst;
  logic                   ovf_new;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add-3 correction, then the combined {bcd_acc, bin_sh} left shift.
  always_comb begin
    adj_acc = bcd_acc_q;
    for (int unsigned i = 0; i < 10; i++) begin
      if (bcd_acc_q[4*i +: 4] >= 4'd5) begin
        adj_acc[4*i +: 4] = bcd_acc_q[4*i +: 4] + 4'd3;
      end
    end
    shifted_acc = {adj_acc[38:0], bin_sh_q[31]};
  end

  // Formatting of shifted_acc; only consumed on the completion edge.
  always_comb begin
    logic any_nz;
    any_nz  = 1'b0;
    blank   = '0;
    hex_new = '1;
    ovf_new = 1'b0;
    // Walk from the top digit down: a digit blanks while nothing above or at it is nonzero.
    for (int i = 9; i >= 0; i--) begin
      any_nz   = any_nz | (|shifted_acc[4*i +: 4]);
      blank[i] = (i != 0) && !any_nz;
    end
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      hex_new[7*i +: 7] = blank[i] ? 7'b1111111 : seg7(shifted_acc[4*i +: 4]);
    end
    for (int unsigned i = 0; i < 10; i++) begin
      if (i >= NDIGITS) begin
        ovf_new = ovf_new | (|shifted_acc[4*i +: 4]);
      end
    end
    hex_rst      = '1;
    hex_rst[6:0] = 7'b1000000;
  end

  always_comb begin
    state_d     = state_q;
    bin_sh_d    = bin_sh_q;
    bcd_acc_d   = bcd_acc_q;
    cnt_d       = cnt_q;
    pend_v_d    = pend_v_q;
    pend_data_d = pend_data_q;
    bcd_d       = bcd_q;
    hex_d       = hex_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.gpio_we) begin
          bin_sh_d  = bus.gpio_data;
          bcd_acc_d = '0;
          cnt_d     = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        bcd_acc_d = shifted_acc;
        bin_sh_d  = {bin_sh_q[30:0], 1'b0};
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          bcd_d  = shifted_acc[4*NDIGITS-1:0];
          hex_d  = hex_new;
          ovf_d  = ovf_new;
          done_d = 1'b1;
          // A write on this very edge is newer than anything pending.
          if (bus.gpio_we || pend_v_q) begin
            bin_sh_d  = bus.gpio_we ? bus.gpio_data : pend_data_q;
            bcd_acc_d = '0;
            cnt_d     = '0;
            pend_v_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else if (bus.gpio_we) begin
          pend_v_d    = 1'b1;
          pend_data_d = bus.gpio_data;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bin_sh_q    <= '0;
      bcd_acc_q   <= '0;
      cnt_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_data_q <= '0;
      bcd_q       <= '0;
      hex_q       <= hex_rst;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_sh_q    <= bin_sh_d;
      bcd_acc_q   <= bcd_acc_d;
      cnt_q       <= cnt_d;
      pend_v_q    <= pend_v_d;
      pend_data_q <= pend_data_d;
      bcd_q       <= bcd_d;
      hex_q       <= hex_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy = (state_q == StShift);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.hex  = hex_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_gpio_bcd_display.sv
// tb_gpio_bcd_display: directed vectors plus multi-cycle sequences for the
// pending buffer and reset abort. Two DUTs share stimulus: NDIGITS=8 and 10.
module tb_gpio_bcd_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [31:0] data;

  int n_pass  = 0;
  int n_total = 0;

  gpio_bcd_display_if #(.NDIGITS(8))  u_if8 ();
  gpio_bcd_display_if #(.NDIGITS(10)) u_if10 ();

  assign u_if8.gpio_we    = we;
  assign u_if8.gpio_data  = data;
  assign u_if10.gpio_we   = we;
  assign u_if10.gpio_data = data;

  gpio_bcd_display #(.NDIGITS(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if8)
  );

  gpio_bcd_display #(.NDIGITS(10)) u_dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if10)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] data;
    logic [31:0] bcd8;
    int          nblank;  // leading digits blanked on the 8-digit display
    logic        ovf8;
    logic [39:0] bcd10;
  } vec_t;

  vec_t vecs [6];

  localparam logic [55:0] Hex8Rst = {49'h1_FFFF_FFFF_FFFF, 7'b1000000};

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d < 4'd10) ? tbl[d] : 7'b1111111;
  endfunction

  function automatic logic [55:0] exp_hex8(input logic [31:0] b, input int nblank);
    logic [55:0] h;
    for (int i = 0; i < 8; i++) begin
      h[7*i +: 7] = (i >= 8 - nblank) ? 7'b1111111 : seg_ref(b[4*i +: 4]);
    end
    return h;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Writes 5 at n=0, 100 at n=10 (pending) and 7 at n=t3; sample n sees edge n-1.
  task automatic run_seq(input int t3, input string tag);
    int          done_cnt = 0;
    int          done_at [2] = '{0, 0};
    logic [31:0] done_bcd [2] = '{32'h0, 32'h0};
    int          busy_gap = 0;
    int          saw100 = 0;
    for (int n = 0; n <= 100; n++) begin
      @(negedge clk);
      if (n > 0) begin
        if (u_if8.done) begin
          if (done_cnt < 2) begin
            done_at[done_cnt]  = n;
            done_bcd[done_cnt] = u_if8.bcd;
          end
          done_cnt++;
        end
        if (n <= 64 && !u_if8.busy) busy_gap++;
        if (u_if8.bcd == 32'h100) saw100++;
      end
      we   = (n == 0) || (n == 10) || (n == t3);
      data = (n == 0) ? 32'd5 : (n == 10) ? 32'd100 : 32'd7;
    end
    we = 1'b0;
    check({tag, " done count"}, done_cnt, 2);
    check({tag, " first done time"}, done_at[0], 33);
    check({tag, " second done time"}, done_at[1], 65);
    check({tag, " first bcd"}, done_bcd[0], 32'h5);
    check({tag, " second bcd"}, done_bcd[1], 32'h7);
    check({tag, " busy gap"}, busy_gap, 0);
    check({tag, " 100 displayed"}, saw100, 0);
    check({tag, " busy at end"}, u_if8.busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{32'd12345678,  32'h12345678, 0, 1'b0, 40'h0012345678};
    vecs[1] = '{32'hFFFFFFFF,  32'h94967295, 0, 1'b1, 40'h4294967295};
    vecs[2] = '{32'd1000,      32'h00001000, 4, 1'b0, 40'h0000001000};
    vecs[3] = '{32'd0,         32'h00000000, 7, 1'b0, 40'h0000000000};
    vecs[4] = '{32'd100000000, 32'h00000000, 0, 1'b1, 40'h0100000000};
    vecs[5] = '{32'd9,         32'h00000009, 7, 1'b0, 40'h0000000009};

    rst_n = 1'b0;
    we    = 1'b0;
    data  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reset busy", u_if8.busy, 1'b0);
    check("reset done", u_if8.done, 1'b0);
    check("reset bcd", u_if8.bcd, 32'h0);
    check("reset ovf", u_if8.ovf, 1'b0);
    check("reset hex0", u_if8.hex[6:0], 7'b1000000);
    check("reset hex upper", u_if8.hex[55:7], {49{1'b1}});
    check("reset hex10 upper", u_if10.hex[69:7], {63{1'b1}});

    for (int k = 0; k < 6; k++) begin
      int   n;
      int   busy_cnt;
      logic got_done;
      @(negedge clk);
      we   = 1'b1;
      data = vecs[k].data;
      @(negedge clk);
      we       = 1'b0;
      n        = 1;
      busy_cnt = u_if8.busy ? 1 : 0;
      got_done = u_if8.done;
      while (!got_done && n < 40) begin
        @(negedge clk);
        n++;
        if (u_if8.busy) busy_cnt++;
        got_done = u_if8.done;
      end
      check($sformatf("vec%0d latency", k), n, 33);
      check($sformatf("vec%0d busy cycles", k), busy_cnt, 32);
      check($sformatf("vec%0d bcd", k), u_if8.bcd, vecs[k].bcd8);
      check($sformatf("vec%0d hex", k), u_if8.hex, exp_hex8(vecs[k].bcd8, vecs[k].nblank));
      check($sformatf("vec%0d ovf", k), u_if8.ovf, vecs[k].ovf8);
      check($sformatf("vec%0d done10", k), u_if10.done, 1'b1);
      check($sformatf("vec%0d bcd10", k), u_if10.bcd, vecs[k].bcd10);
      check($sformatf("vec%0d ovf10", k), u_if10.ovf, 1'b0);
      if (k == 0) begin
        check("vec0 hex digit0", u_if8.hex[6:0], 7'b0000000);
        check("vec0 hex digit1", u_if8.hex[13:7], 7'b1111000);
        check("vec0 hex digit7", u_if8.hex[55:49], 7'b1111001);
      end
      @(negedge clk);
      check($sformatf("vec%0d done width", k), u_if8.done, 1'b0);
    end

    run_seq(20, "pend");
    run_seq(32, "we on completion");

    // Reset mid-conversion must abort with no done pulse.
    begin
      int done_cnt = 0;
      for (int n = 0; n <= 56; n++) begin
        @(negedge clk);
        if (n > 0 && u_if8.done) done_cnt++;
        we    = (n == 0);
        data  = 32'd999;
        rst_n = !(n == 15);
      end
      we    = 1'b0;
      rst_n = 1'b1;
      check("abort done count", done_cnt, 0);
      check("abort busy", u_if8.busy, 1'b0);
      check("abort bcd", u_if8.bcd, 32'h0);
      check("abort ovf", u_if8.ovf, 1'b0);
      check("abort hex", u_if8.hex, Hex8Rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
